// File: rtl/cc_branch_unit.sv
// cc_branch_unit: LC-3 condition codes (N/Z/P), branch enable and a small
// LIFO that saves/restores the flags across interrupt entry and RTI.
//
// Request semantics: there is no valid/ready handshake. Every request input
// (LD_CC, LD_BEN, Push, Pop, Clear_err) is sampled on each rising edge, and
// one action is performed per cycle while it is high. Push and Pop together
// is a protocol error: neither takes effect. Push when full and Pop when
// empty are dropped and recorded in sticky flags.
module cc_branch_unit #(
    parameter int         WIDTH       = 16,
    parameter int         STACK_DEPTH = 4,
    parameter logic [2:0] CC_RESET    = 3'b010
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic [WIDTH-1:0]                   Bus,
    input  logic                               LD_CC,
    input  logic                               LD_BEN,
    input  logic [2:0]                         IR_nzp,
    input  logic                               Push,
    input  logic                               Pop,
    input  logic                               Clear_err,
    output logic [2:0]                         NZP,
    output logic                               BEN,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   Depth,
    output logic                               Empty,
    output logic                               Full,
    output logic                               Overflow,
    output logic                               Underflow,
    output logic                               Proto_err
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [2:0]    stack [STACK_DEPTH];
    logic [2:0]    bus_flags;
    logic          flag_n;
    logic          flag_z;
    logic          both_req;
    logic          push_ok;
    logic          pop_ok;
    logic          push_full;
    logic          pop_empty;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    // Flags derived from the bus value; exactly one bit is ever set.
    assign flag_n    = Bus[WIDTH-1];
    assign flag_z    = (Bus == '0);
    assign bus_flags = {flag_n, flag_z, ~flag_n & ~flag_z};

    assign Empty = (Depth == '0);
    assign Full  = (Depth == DW'(STACK_DEPTH));

    // Push and Pop together cancel each other; otherwise each is legal only
    // when the stack has room / has an entry.
    assign both_req  = Push & Pop;
    assign push_ok   = Push & ~Pop & ~Full;
    assign pop_ok    = Pop & ~Push & ~Empty;
    assign push_full = Push & ~Pop & Full;
    assign pop_empty = Pop & ~Push & Empty;

    // Write slot is the current depth; read slot is the entry below it.
    assign wr_idx = AW'(Depth);
    assign rd_idx = AW'(Depth - 1'b1);

    // Stack storage: contents are don't-care outside [0, Depth), so no reset.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            stack[wr_idx] <= NZP;
        end
    end

    // Flags, branch enable, depth and sticky errors.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            NZP       <= CC_RESET;
            BEN       <= 1'b0;
            Depth     <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            Proto_err <= 1'b0;
        end else begin
            // A restore from the stack beats a fresh load from the bus.
            if (pop_ok) begin
                NZP <= stack[rd_idx];
            end else if (LD_CC) begin
                NZP <= bus_flags;
            end

            // BEN always looks at the flags as they were before this edge.
            if (LD_BEN) begin
                BEN <= |(IR_nzp & NZP);
            end

            if (push_ok) begin
                Depth <= Depth + 1'b1;
            end else if (pop_ok) begin
                Depth <= Depth - 1'b1;
            end

            // A new error in the clearing cycle keeps its flag set.
            Overflow  <= push_full | (Overflow  & ~Clear_err);
            Underflow <= pop_empty | (Underflow & ~Clear_err);
            Proto_err <= both_req  | (Proto_err & ~Clear_err);
        end
    end

endmodule

// File: tb/tb_cc_branch_unit.sv
// Testbench for cc_branch_unit: directed scenarios plus a randomized run,
// all checked against a queue-based behavioural model of the flag stack.
module tb_cc_branch_unit;

    localparam int WIDTH = 16;
    localparam int SD    = 4;
    localparam int DW    = $clog2(SD + 1);

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic [WIDTH-1:0] Bus = '0;
    logic             LD_CC = 1'b0;
    logic             LD_BEN = 1'b0;
    logic [2:0]       IR_nzp = '0;
    logic             Push = 1'b0;
    logic             Pop = 1'b0;
    logic             Clear_err = 1'b0;
    logic [2:0]       NZP;
    logic             BEN;
    logic [DW-1:0]    Depth;
    logic             Empty;
    logic             Full;
    logic             Overflow;
    logic             Underflow;
    logic             Proto_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [2:0] m_nzp;
    logic       m_ben;
    logic [2:0] m_stack[$];
    logic       m_ovf;
    logic       m_unf;
    logic       m_proto;

    cc_branch_unit #(.WIDTH(WIDTH), .STACK_DEPTH(SD), .CC_RESET(3'b010)) dut (
        .Clk(Clk), .Reset(Reset), .Bus(Bus), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
        .IR_nzp(IR_nzp), .Push(Push), .Pop(Pop), .Clear_err(Clear_err),
        .NZP(NZP), .BEN(BEN), .Depth(Depth), .Empty(Empty), .Full(Full),
        .Overflow(Overflow), .Underflow(Underflow), .Proto_err(Proto_err)
    );

    // Clock / watchdog
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // Flags from a bus value, by sign and magnitude.
    function automatic logic [2:0] flags_of(input logic [WIDTH-1:0] v);
        if (v == 0) return 3'b010;
        if (v >= (1 << (WIDTH - 1))) return 3'b100;
        return 3'b001;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [2:0] old_nzp;
        logic       restored;
        logic [2:0] rest_val;
        old_nzp  = m_nzp;
        restored = 1'b0;
        rest_val = 3'b000;
        if (Reset) begin
            m_nzp = 3'b010; m_ben = 1'b0; m_stack.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_proto = 1'b0;
            return;
        end
        if (Clear_err) begin
            m_ovf = 1'b0; m_unf = 1'b0; m_proto = 1'b0;
        end
        if (LD_BEN) m_ben = |(IR_nzp & old_nzp);
        if (Push && Pop) begin
            m_proto = 1'b1;
        end else if (Push) begin
            if (m_stack.size() == SD) m_ovf = 1'b1;
            else m_stack.push_back(old_nzp);
        end else if (Pop) begin
            if (m_stack.size() == 0) m_unf = 1'b1;
            else begin
                rest_val = m_stack.pop_back();
                restored = 1'b1;
            end
        end
        if (restored) m_nzp = rest_val;
        else if (LD_CC) m_nzp = flags_of(Bus);
    endtask

    // One clock: update model, clock the DUT, settle, drop request pulses.
    task automatic cyc();
        model_step();
        @(posedge Clk);
        #1;
        Reset = 1'b0; LD_CC = 1'b0; LD_BEN = 1'b0;
        Push = 1'b0; Pop = 1'b0; Clear_err = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        cyc();
        total++;
        if (NZP !== 3'b010) begin bad++; $display("FAIL reset_nzp: got %b want 010", NZP); end
        total++;
        if (BEN !== 1'b0) begin bad++; $display("FAIL reset_ben: got %b want 0", BEN); end
        total++;
        if ({Depth, Empty, Full} !== {3'd0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL reset_depth: depth=%0d empty=%b full=%b want 0/1/0", Depth, Empty, Full);
        end
        total++;
        if ({Overflow, Underflow, Proto_err} !== 3'b000) begin
            bad++; $display("FAIL reset_sticky: got %b want 000", {Overflow, Underflow, Proto_err});
        end
    endtask

    task automatic test_ld_cc();
        logic [WIDTH-1:0] vals [3];
        logic [2:0]       want [3];
        vals = '{16'h8000, 16'h0000, 16'h0001};
        want = '{3'b100, 3'b010, 3'b001};
        for (int i = 0; i < 3; i++) begin
            Bus = vals[i]; LD_CC = 1'b1;
            cyc();
            total++;
            if (NZP !== want[i]) begin
                bad++; $display("FAIL ld_cc_%0d: bus=%h got %b want %b", i, vals[i], NZP, want[i]);
            end
        end
    endtask

    task automatic test_ben();
        IR_nzp = 3'b110; LD_BEN = 1'b1;
        cyc();
        total++;
        if (BEN !== 1'b0) begin bad++; $display("FAIL ben_miss: got %b want 0", BEN); end
        cyc();
        total++;
        if (BEN !== 1'b0) begin bad++; $display("FAIL ben_hold: got %b want 0", BEN); end
        IR_nzp = 3'b001; LD_BEN = 1'b1;
        cyc();
        total++;
        if (BEN !== 1'b1) begin bad++; $display("FAIL ben_hit: got %b want 1", BEN); end
    endtask

    task automatic test_hazard();
        Bus = 16'h8000; LD_CC = 1'b1;
        cyc();
        Bus = 16'h0000; LD_CC = 1'b1; IR_nzp = 3'b100; LD_BEN = 1'b1;
        cyc();
        total++;
        if (BEN !== 1'b1) begin bad++; $display("FAIL hazard_ben: got %b want 1", BEN); end
        total++;
        if (NZP !== 3'b010) begin bad++; $display("FAIL hazard_nzp: got %b want 010", NZP); end
        // Back-to-back: LD_BEN right after LD_CC sees the new flags.
        IR_nzp = 3'b100; LD_BEN = 1'b1;
        cyc();
        total++;
        if (BEN !== 1'b0) begin bad++; $display("FAIL b2b_ben: got %b want 0", BEN); end
    endtask

    task automatic test_stack();
        logic [WIDTH-1:0] vals [4];
        logic [2:0]       want [4];
        vals = '{16'h0001, 16'h8000, 16'h0000, 16'h7FFF};
        want = '{3'b001, 3'b100, 3'b010, 3'b001};
        for (int i = 0; i < 4; i++) begin
            Bus = vals[i]; LD_CC = 1'b1;
            cyc();
            Push = 1'b1;
            cyc();
        end
        total++;
        if ({Full, Depth} !== {1'b1, 3'd4}) begin
            bad++; $display("FAIL fill: full=%b depth=%0d want 1/4", Full, Depth);
        end
        Push = 1'b1;
        cyc();
        total++;
        if ({Overflow, Depth} !== {1'b1, 3'd4}) begin
            bad++; $display("FAIL overflow: ovf=%b depth=%0d want 1/4", Overflow, Depth);
        end
        for (int i = 3; i >= 0; i--) begin
            Bus = 16'h8000; Pop = 1'b1; LD_CC = (i == 2);
            cyc();
            total++;
            if (NZP !== want[i]) begin
                bad++; $display("FAIL pop_%0d: got %b want %b", i, NZP, want[i]);
            end
        end
        total++;
        if ({Empty, Depth} !== {1'b1, 3'd0}) begin
            bad++; $display("FAIL drain: empty=%b depth=%0d want 1/0", Empty, Depth);
        end
        Pop = 1'b1;
        cyc();
        total++;
        if ({Underflow, NZP} !== {1'b1, 3'b001}) begin
            bad++; $display("FAIL underflow: unf=%b nzp=%b want 1/001", Underflow, NZP);
        end
        // Clearing in the same cycle as a new underflow keeps it set.
        Pop = 1'b1; Clear_err = 1'b1;
        cyc();
        total++;
        if ({Overflow, Underflow} !== 2'b01) begin
            bad++; $display("FAIL clear_vs_new: got %b want 01", {Overflow, Underflow});
        end
        Clear_err = 1'b1;
        cyc();
        total++;
        if ({Overflow, Underflow, Proto_err} !== 3'b000) begin
            bad++; $display("FAIL clear: got %b want 000", {Overflow, Underflow, Proto_err});
        end
    endtask

    task automatic test_push_ldcc();
        Bus = 16'h0001; LD_CC = 1'b1;
        cyc();
        Bus = 16'hFFFF; LD_CC = 1'b1; Push = 1'b1;
        cyc();
        total++;
        if ({NZP, Depth} !== {3'b100, 3'd1}) begin
            bad++; $display("FAIL push_ldcc: nzp=%b depth=%0d want 100/1", NZP, Depth);
        end
        Pop = 1'b1;
        cyc();
        total++;
        if ({NZP, Depth} !== {3'b001, 3'd0}) begin
            bad++; $display("FAIL push_ldcc_pop: nzp=%b depth=%0d want 001/0", NZP, Depth);
        end
    endtask

    task automatic test_proto();
        Push = 1'b1;
        cyc();
        Bus = 16'h0000; LD_CC = 1'b1; Push = 1'b1;
        cyc();
        Push = 1'b1; Pop = 1'b1;
        cyc();
        total++;
        if ({Proto_err, Depth, NZP} !== {1'b1, 3'd2, 3'b010}) begin
            bad++; $display("FAIL proto: err=%b depth=%0d nzp=%b want 1/2/010", Proto_err, Depth, NZP);
        end
    endtask

    task automatic test_reset_mid();
        Push = 1'b1;
        cyc();
        total++;
        if (Depth !== 3'd3) begin bad++; $display("FAIL pre_reset_depth: got %0d want 3", Depth); end
        Reset = 1'b1; Push = 1'b1; LD_CC = 1'b1; Bus = 16'h8000;
        cyc();
        total++;
        if ({Depth, Empty, NZP, Proto_err} !== {3'd0, 1'b1, 3'b010, 1'b0}) begin
            bad++; $display("FAIL mid_reset: depth=%0d empty=%b nzp=%b err=%b want 0/1/010/0", Depth, Empty, NZP, Proto_err);
        end
        Pop = 1'b1;
        cyc();
        total++;
        if ({Underflow, Depth} !== {1'b1, 3'd0}) begin
            bad++; $display("FAIL reset_then_pop: unf=%b depth=%0d want 1/0", Underflow, Depth);
        end
    endtask

    task automatic test_random();
        logic [11:0] got;
        logic [11:0] exp;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       Bus = '0;
                1:       Bus = WIDTH'($urandom) | (WIDTH'(1) << (WIDTH - 1));
                default: Bus = WIDTH'($urandom);
            endcase
            IR_nzp    = 3'($urandom_range(0, 7));
            LD_CC     = ($urandom_range(0, 2) == 0);
            LD_BEN    = ($urandom_range(0, 2) == 0);
            Push      = ($urandom_range(0, 2) == 0);
            Pop       = ($urandom_range(0, 2) == 0);
            Clear_err = ($urandom_range(0, 9) == 0);
            Reset     = ($urandom_range(0, 63) == 0);
            cyc();
            got = {NZP, BEN, Depth, Empty, Full, Overflow, Underflow, Proto_err};
            exp = {m_nzp, m_ben, DW'(m_stack.size()), m_stack.size() == 0,
                   m_stack.size() == SD, m_ovf, m_unf, m_proto};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random_%0d: nzp/ben/depth/e/f/ovf/unf/perr got %b want %b", n, got, exp);
            end
        end
    endtask

    initial begin
        m_nzp = 3'b010; m_ben = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0; m_proto = 1'b0;
        @(posedge Clk);
        #1;
        test_reset();
        test_ld_cc();
        test_ben();
        test_hazard();
        test_reset();
        test_stack();
        test_push_ldcc();
        test_proto();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cc_branch_unit.md
# cc_branch_unit

Parametrised condition-code and branch-enable unit for the LC-3 datapath. It derives N/Z/P from a WIDTH-bit bus value, registers the flags, and computes BEN against the IR's nzp field. It adds a STACK_DEPTH-entry save/restore stack so interrupt entry (push) and RTI (pop) can preserve the flags, with sticky overflow, underflow and protocol error flags. It sits beside the IR and PC logic and is driven by the control FSM.

## Interface
- WIDTH, 16, data bus width (≥2)
- STACK_DEPTH, 4, number of saved-flag entries (≥1)
- CC_RESET, 3'b010, NZP value after reset (one-hot)
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Bus  in  WIDTH  value the condition codes are derived from
- LD_CC  in  1  load NZP from Bus
- LD_BEN  in  1  load BEN from IR_nzp and the current NZP
- IR_nzp  in  3  branch condition mask {n,z,p}
- Push  in  1  save the current NZP onto the stack
- Pop  in  1  restore NZP from the top of the stack
- Clear_err  in  1  clear the sticky error flags
- NZP  out  3  registered flags {N,Z,P}, always one-hot
- BEN  out  1  registered branch enable
- Depth  out  $clog2(STACK_DEPTH+1)  number of valid stack entries
- Empty  out  1  Depth==0
- Full  out  1  Depth==STACK_DEPTH
- Overflow  out  1  sticky: push attempted while full
- Underflow  out  1  sticky: pop attempted while empty
- Proto_err  out  1  sticky: Push and Pop asserted together

## Operation
- Flag derivation (combinational, from Bus):
  - N = Bus[WIDTH-1].
  - Z = (Bus == 0).
  - P = ~N & ~Z.
  - Exactly one bit is set.
- LD_CC: NZP <= derived flags.
- LD_BEN: BEN <= |(IR_nzp & NZP).
  - Uses the NZP value registered before this edge, even if LD_CC or Pop is active in the same cycle.
  - BEN holds its value when LD_BEN is low.
- Push, not Full:
  - stack[Depth] <= NZP (the pre-edge value).
  - Depth increments.
- Pop, not Empty:
  - NZP <= stack[Depth-1].
  - Depth decrements.
- Priority for NZP when several requests coincide: valid Pop > LD_CC > hold.
  - Push with LD_CC: the old NZP is saved and the new flags are loaded.
  - Pop with LD_CC: the restored value wins and LD_CC is ignored.
- Push while Full:
  - Stack and Depth unchanged.
  - Overflow <= 1.
  - LD_CC still applies.
- Pop while Empty:
  - NZP and Depth unchanged, apart from LD_CC, which still applies.
  - Underflow <= 1.
- Push and Pop in the same cycle:
  - Both are ignored; stack, Depth and the pop restore are unchanged.
  - Proto_err <= 1.
  - LD_CC and LD_BEN act normally.
- Clear_err clears all sticky flags. A new error in the same cycle wins, so that flag stays set.
- Empty and Full are decoded directly from Depth.
- The stack is LIFO with no wrap-around. Entries at or above Depth are don't-care and are not cleared on pop.

## Timing
- All outputs are registered; every update takes effect 1 cycle after the request edge.
- Reset (synchronous, dominates all inputs):
  - NZP = CC_RESET, BEN = 0, Depth = 0, Empty = 1, Full = 0.
  - Overflow = Underflow = Proto_err = 0.
  - Stack contents are don't-care.
- Reset mid-sequence discards all saved entries. The next Pop reports Underflow.
- Back-to-back operations are legal every cycle: Push/Push, Pop/Pop, LD_CC followed by LD_BEN.
  - LD_BEN in the cycle after LD_CC sees the new flags.
- No handshake: requests are single-cycle pulses, and a level held high repeats the action each cycle.

## Test plan
- Reset, then LD_CC with Bus=16'h8000, 16'h0000 and 16'h0001 in turn:
  - NZP = 100, 010, 001 respectively.
  - Output values after reset: NZP=010, BEN=0, Empty=1.
- NZP=001, then LD_BEN with IR_nzp=110 → BEN=0. Next LD_BEN with IR_nzp=001 → BEN=1.
- Same-cycle hazard: NZP=100, assert LD_CC (Bus=0) and LD_BEN (IR_nzp=100) together:
  - BEN=1, because the old flags are used.
  - NZP=010.
- Fill and overflow (STACK_DEPTH=4):
  - Push 4 distinct flag values → Full=1, Depth=4.
  - 5th Push → Overflow=1, Depth stays 4.
  - Pop ×4 restores the values in reverse order → Empty=1.
  - 5th Pop → Underflow=1, NZP unchanged.
  - Clear_err → all sticky flags 0.
- Push with LD_CC: NZP=001, Push + LD_CC (Bus=16'hFFFF) → NZP=100. A following Pop → NZP=001.
- Push and Pop together at Depth=2 → Proto_err=1, Depth=2, NZP unchanged.
- Reset asserted at Depth=3 → Depth=0, Empty=1. The next Pop → Underflow=1.
